// File: rtl/tree_rr_arbiter_pkg.sv
// Shared sizing helpers for the tree round-robin arbiter.
package tree_rr_arbiter_pkg;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Node count of a complete binary tree with the given number of levels.
  function automatic int unsigned tree_nodes(input int unsigned levels);
    return (32'd1 << levels) - 32'd1;
  endfunction

endpackage

// File: rtl/tree_rr_arbiter_if.sv
// Requester-side and downstream valid/ready bundle of the arbiter.
interface tree_rr_arbiter_if
  import tree_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = idx_width(NumIn)
);

  logic [NumIn-1:0]           req_valid_i;
  logic [NumIn-1:0]           req_ready_o;
  logic [NumIn*DataWidth-1:0] req_data_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [DataWidth-1:0]       out_data_o;
  logic [IdxWidth-1:0]        out_idx_o;

  // Environment side: drives requests and downstream ready.
  modport master (
    output req_valid_i, req_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_idx_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_idx_o
  );

endinterface

// File: rtl/tree_rr_arbiter_tree_first_one.sv
// Combinational lowest-set-index search built as a binary tree.
// Node (level, l) lives at flat index 2**level-1+l; leaves past NumIn read as invalid.
module tree_first_one
  import tree_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned NumLevels = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic [NumIn-1:0]     vec,
  output logic                 found,
  output logic [NumLevels-1:0] index
);

  localparam int unsigned NumNodes = tree_nodes(NumLevels);

  logic [NumNodes-1:0]  node_valid;
  logic [NumLevels-1:0] node_idx [NumNodes];

  for (genvar level = 0; level < NumLevels; level++) begin : g_level
    for (genvar l = 0; l < 2 ** level; l++) begin : g_node
      localparam int unsigned Node = 2 ** level - 1 + l;
      if (level == NumLevels - 1) begin : g_leaf
        logic lo_v;
        logic hi_v;
        if (2 * l < NumIn) begin : g_lo_real
          assign lo_v = vec[2*l];
        end else begin : g_lo_pad
          assign lo_v = 1'b0;
        end
        if (2 * l + 1 < NumIn) begin : g_hi_real
          assign hi_v = vec[2*l+1];
        end else begin : g_hi_pad
          assign hi_v = 1'b0;
        end
        assign node_valid[Node] = lo_v | hi_v;
        assign node_idx[Node]   = lo_v ? NumLevels'(2 * l) : NumLevels'(2 * l + 1);
      end else begin : g_inner
        localparam int unsigned Lc = 2 ** (level + 1) - 1 + 2 * l;
        localparam int unsigned Rc = Lc + 1;
        assign node_valid[Node] = node_valid[Lc] | node_valid[Rc];
        assign node_idx[Node]   = node_valid[Lc] ? node_idx[Lc] : node_idx[Rc];
      end
    end
  end

  assign found = node_valid[0];
  assign index = node_idx[0];

endmodule

// File: rtl/tree_rr_arbiter.sv
// Round-robin arbiter with grant locking under back-pressure, optional
// external priority pointer and a single-input passthrough.
module tree_rr_arbiter
  import tree_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          ExtPrio   = 1'b0,
  parameter bit          LockIn    = 1'b1,
  parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                flush_i,
  input logic [IdxWidth-1:0] rr_i,
  tree_rr_arbiter_if.slave   bus
);

  if (NumIn == 1) begin : g_bypass
    logic unused_bypass;

    assign bus.out_valid_o = ~rst_i & bus.req_valid_i[0];
    assign bus.req_ready_o = ~rst_i & bus.out_ready_i;
    assign bus.out_data_o  = rst_i ? '0 : bus.req_data_i;
    assign bus.out_idx_o   = '0;
    assign unused_bypass   = ^{clk_i, flush_i, rr_i};

  end else begin : g_arb
    localparam int unsigned NumLevels = $clog2(NumIn);
    localparam int unsigned NumPad    = 2 ** IdxWidth;

    logic [IdxWidth-1:0]  rr_q, rr_d;
    logic                 lock_q, lock_d;
    logic [IdxWidth-1:0]  lock_idx_q, lock_idx_d;

    logic [IdxWidth-1:0]  ptr_raw, ptr;
    logic [NumIn-1:0]     masked;
    logic                 m_found, r_found;
    logic [IdxWidth-1:0]  m_idx, r_idx;
    logic [NumPad-1:0]    valid_ext;
    logic [IdxWidth-1:0]  win;
    logic                 grant_valid;
    logic                 handshake;
    logic [DataWidth-1:0] data_sel;
    logic [NumIn-1:0]     ready_vec;

    assign ptr_raw   = ExtPrio ? rr_i : rr_q;
    assign ptr       = (32'(ptr_raw) >= NumIn) ? '0 : ptr_raw;
    assign valid_ext = NumPad'(bus.req_valid_i);

    // Requests at or after the priority pointer.
    always_comb begin
      masked = '0;
      for (int unsigned k = 0; k < NumIn; k++) begin
        masked[k] = bus.req_valid_i[k] & (k >= 32'(ptr));
      end
    end

    tree_first_one #(.NumIn(NumIn), .NumLevels(NumLevels)) u_masked (
      .vec   (masked),
      .found (m_found),
      .index (m_idx)
    );

    tree_first_one #(.NumIn(NumIn), .NumLevels(NumLevels)) u_raw (
      .vec   (bus.req_valid_i),
      .found (r_found),
      .index (r_idx)
    );

    // Winner selection and handshake outputs; a held lock overrides the search.
    always_comb begin
      win         = m_found ? m_idx : r_idx;
      grant_valid = r_found;
      if (lock_q) begin
        win         = lock_idx_q;
        grant_valid = valid_ext[lock_idx_q];
      end
      if (rst_i) begin
        grant_valid = 1'b0;
      end
      handshake = grant_valid & bus.out_ready_i;
      data_sel  = '0;
      ready_vec = '0;
      for (int unsigned k = 0; k < NumIn; k++) begin
        if (IdxWidth'(k) == win) begin
          data_sel     = bus.req_data_i[k*DataWidth +: DataWidth];
          ready_vec[k] = handshake;
        end
      end
    end

    assign bus.out_valid_o = grant_valid;
    assign bus.out_idx_o   = grant_valid ? win : '0;
    assign bus.out_data_o  = grant_valid ? data_sel : '0;
    assign bus.req_ready_o = ready_vec;

    // Pointer advance, lock capture/release; flush clears everything.
    always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (!ExtPrio && handshake) begin
        rr_d = (32'(win) == NumIn - 1) ? '0 : win + IdxWidth'(1);
      end
      if (LockIn) begin
        if (handshake || !grant_valid) begin
          lock_d = 1'b0;
        end else begin
          lock_d     = 1'b1;
          lock_idx_d = win;
        end
      end
      if (flush_i) begin
        rr_d       = '0;
        lock_d     = 1'b0;
        lock_idx_d = '0;
      end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        rr_q       <= rr_d;
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
      end
    end

    // A locked requester must keep its request up until the handshake.
    lock_hold_a : assert property (@(posedge clk_i) disable iff (rst_i)
                                   lock_q |-> valid_ext[lock_idx_q]);
  end

endmodule

// File: tb/tb_tree_rr_arbiter.sv
// Randomised and directed checks of tree_rr_arbiter against a cyclic-search model.
module tb_tree_rr_arbiter;
  import tree_rr_arbiter_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: internal pointer DUT, index 1: external priority DUT
  logic [N-1:0]    valid [2];
  logic [N*DW-1:0] data  [2];
  logic            ordy  [2];
  logic            flush [2];
  logic [IW-1:0]   rr_in;
  logic            v1, ordy1, flush1, rr1;
  logic [DW-1:0]   d1;

  logic            obs_valid [2];
  logic [N-1:0]    obs_ready [2];
  logic [IW-1:0]   obs_idx   [2];
  logic [DW-1:0]   obs_data  [2];

  tree_rr_arbiter_if #(.NumIn(N), .DataWidth(DW), .IdxWidth(IW)) if_a ();
  tree_rr_arbiter_if #(.NumIn(N), .DataWidth(DW), .IdxWidth(IW)) if_e ();
  tree_rr_arbiter_if #(.NumIn(1), .DataWidth(DW), .IdxWidth(1))  if_s ();

  assign if_a.req_valid_i = valid[0];
  assign if_a.req_data_i  = data[0];
  assign if_a.out_ready_i = ordy[0];
  assign if_e.req_valid_i = valid[1];
  assign if_e.req_data_i  = data[1];
  assign if_e.out_ready_i = ordy[1];
  assign if_s.req_valid_i = v1;
  assign if_s.req_data_i  = d1;
  assign if_s.out_ready_i = ordy1;

  assign obs_valid[0] = if_a.out_valid_o;
  assign obs_ready[0] = if_a.req_ready_o;
  assign obs_idx[0]   = if_a.out_idx_o;
  assign obs_data[0]  = if_a.out_data_o;
  assign obs_valid[1] = if_e.out_valid_o;
  assign obs_ready[1] = if_e.req_ready_o;
  assign obs_idx[1]   = if_e.out_idx_o;
  assign obs_data[1]  = if_e.out_data_o;

  tree_rr_arbiter #(.NumIn(N), .DataWidth(DW), .ExtPrio(1'b0), .LockIn(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .rr_i(rr_in), .bus(if_a));
  tree_rr_arbiter #(.NumIn(N), .DataWidth(DW), .ExtPrio(1'b1), .LockIn(1'b1)) dut_e (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .rr_i(rr_in), .bus(if_e));
  tree_rr_arbiter #(.NumIn(1), .DataWidth(DW), .ExtPrio(1'b0), .LockIn(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .rr_i(rr1), .bus(if_s));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state
  int m_rr   [2];
  bit m_lock [2];
  int m_lidx [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Grant: held lock, else first valid index scanning cyclically from the pointer.
  function automatic void model_eval(input int d, output bit ev, output int w);
    int p;
    ev = 1'b0;
    w  = 0;
    if (rst) return;
    p = (d == 1) ? int'(rr_in) : m_rr[d];
    if (p >= int'(N)) p = 0;
    if (m_lock[d]) begin
      w  = m_lidx[d];
      ev = valid[d][w];
      return;
    end
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (p + i) % int'(N);
      if (valid[d][k]) begin
        w  = k;
        ev = 1'b1;
        return;
      end
    end
  endfunction

  // Compare every output against the model, advance the model, step one clock.
  task automatic tick();
    bit           ev;
    int           w;
    logic [N-1:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_eval(d, ev, w);
      er = (ev && ordy[d]) ? N'(1 << w) : '0;
      check($sformatf("out_valid[%0d]", d), 64'(obs_valid[d]), 64'(ev));
      check($sformatf("out_idx[%0d]", d),   64'(obs_idx[d]),   ev ? 64'(w) : 64'(0));
      check($sformatf("req_ready[%0d]", d), 64'(obs_ready[d]), 64'(er));
      check($sformatf("out_data[%0d]", d),  64'(obs_data[d]),  ev ? 64'(data[d][w*DW +: DW]) : 64'(0));
      if (rst || flush[d]) begin
        m_rr[d]   = 0;
        m_lock[d] = 1'b0;
        m_lidx[d] = 0;
      end else begin
        if (ev && ordy[d] && d == 0) m_rr[d] = (w + 1) % int'(N);
        m_lock[d] = ev && !ordy[d];
        if (m_lock[d]) m_lidx[d] = w;
      end
    end
    check("single_valid", 64'(if_s.out_valid_o), rst ? 64'(0) : 64'(v1));
    check("single_ready", 64'(if_s.req_ready_o), rst ? 64'(0) : 64'(ordy1));
    check("single_idx",   64'(if_s.out_idx_o),   64'(0));
    check("single_data",  64'(if_s.out_data_o),  rst ? 64'(0) : 64'(d1));
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  int seq [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst = 1'b1;
    rr_in = '0; rr1 = 1'b0; flush1 = 1'b0;
    v1 = 1'b0; ordy1 = 1'b0; d1 = '0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; data[d] = 40'h0403020100 + 40'(d) * 40'h1010101010;
      ordy[d] = 1'b0; flush[d] = 1'b0;
      m_rr[d] = 0; m_lock[d] = 1'b0; m_lidx[d] = 0;
    end
    @(negedge clk);
    tick();
    // outputs stay quiet under reset even with requests pending
    valid[0] = '1; valid[1] = '1; ordy[0] = 1'b1; ordy[1] = 1'b1; v1 = 1'b1; ordy1 = 1'b1; d1 = 8'h5a;
    tick();
    rst = 1'b0;
    valid[1] = '0;

    // full rotation with everyone requesting
    for (int i = 0; i < 6; i++) begin
      #1 check("rotate_idx", 64'(obs_idx[0]), 64'(seq[i]));
      tick();
    end

    // wrap below the pointer, then resume after the winner
    valid[0] = 5'b00100; tick();
    valid[0] = 5'b00101;
    #1 check("wrap_idx", 64'(obs_idx[0]), 64'(0));
    tick();
    #1 check("after_wrap_idx", 64'(obs_idx[0]), 64'(2));
    tick();

    // lock under back-pressure
    valid[0] = 5'b00010; ordy[0] = 1'b0; tick();
    valid[0] = 5'b00011;
    #1 check("lock_idx", 64'(obs_idx[0]), 64'(1));
    check("lock_ready", 64'(obs_ready[0]), 64'(0));
    tick(); tick();
    ordy[0] = 1'b1;
    #1 check("lock_release_ready", 64'(obs_ready[0]), 64'(5'b00010));
    tick();
    valid[0] = '1;
    #1 check("post_lock_idx", 64'(obs_idx[0]), 64'(2));
    tick();

    // external pointer, including out of range
    valid[0] = '0;
    valid[1] = 5'b11011; ordy[1] = 1'b1; rr_in = 3'd3;
    #1 check("ext_idx", 64'(obs_idx[1]), 64'(3));
    tick();
    rr_in = 3'd7;
    #1 check("ext_oor_idx", 64'(obs_idx[1]), 64'(0));
    tick();
    valid[1] = '0;

    // reset while locked on 4 with rr at 4
    valid[0] = 5'b01000; ordy[0] = 1'b1; tick();
    valid[0] = 5'b10000; ordy[0] = 1'b0; tick();
    rst = 1'b1; valid[0] = '1;
    #1 check("rst_lock_valid", 64'(obs_valid[0]), 64'(0));
    check("rst_lock_ready", 64'(obs_ready[0]), 64'(0));
    tick();
    rst = 1'b0; ordy[0] = 1'b1;
    #1 check("rst_after_idx", 64'(obs_idx[0]), 64'(0));
    tick();

    // same with flush
    valid[0] = 5'b01000; ordy[0] = 1'b1; tick();
    valid[0] = 5'b10000; ordy[0] = 1'b0; tick();
    flush[0] = 1'b1; valid[0] = '1; tick();
    flush[0] = 1'b0; ordy[0] = 1'b1;
    #1 check("flush_after_idx", 64'(obs_idx[0]), 64'(0));
    tick();

    // flush beats a simultaneous handshake
    valid[0] = 5'b00010; flush[0] = 1'b1; tick();
    flush[0] = 1'b0; valid[0] = 5'b00110;
    #1 check("flush_hs_idx", 64'(obs_idx[0]), 64'(1));
    tick();

    // single-input passthrough
    for (int i = 0; i < 4; i++) begin
      v1 = i[0]; ordy1 = i[1]; d1 = 8'(8'h30 + i);
      tick();
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      rr_in = IW'($urandom_range(0, 7));
      for (int d = 0; d < 2; d++) begin
        valid[d] = N'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) valid[d] = '0;
        if (m_lock[d]) valid[d][m_lidx[d]] = 1'b1;
        data[d]  = 40'({$urandom, $urandom});
        ordy[d]  = ($urandom_range(0, 3) != 0);
        flush[d] = ($urandom_range(0, 24) == 0);
      end
      v1 = 1'($urandom); ordy1 = 1'($urandom); d1 = 8'($urandom);
      flush1 = 1'($urandom); rr1 = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
